cordic_req_arbiter: RTL

CORDIC_REQ_ARBITER -- requirements
Module: cordic_req_arbiter

---
 rtl/cordic_arb_pkg.sv | 14 +
 rtl/cordic_req_arbiter_if.sv | 52 +++++
 rtl/cordic_rr_picker.sv | 31 +++
 rtl/cordic_req_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cordic_arb_pkg.sv
// Shared types for the CORDIC request arbiter: FSM state encoding and the
// default watchdog limit.
package cordic_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } arb_state_t;

    localparam int TIMEOUT_CYC_DEF = 32;

endpackage

// File: rtl/cordic_req_arbiter_if.sv
// Requester, engine and response signals of the arbiter; slave = arbiter side.
// Requester operands are packed [NUM_REQ][WIDTH] buses.
interface cordic_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_mode;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_x;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_y;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_z;

    logic             eng_valid_in;
    logic             eng_mode;
    logic [WIDTH-1:0] eng_x;
    logic [WIDTH-1:0] eng_y;
    logic [WIDTH-1:0] eng_z;
    logic             eng_valid_out;
    logic [WIDTH-1:0] eng_cos;
    logic [WIDTH-1:0] eng_sin;
    logic [WIDTH-1:0] eng_tan_in;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [WIDTH-1:0] rsp_cos;
    logic [WIDTH-1:0] rsp_sin;
    logic [WIDTH-1:0] rsp_atan;
    logic             rsp_err;

    modport slave (
        input  req_valid, req_mode, req_x, req_y, req_z,
        input  eng_valid_out, eng_cos, eng_sin, eng_tan_in,
        input  rsp_ready,
        output req_ready,
        output eng_valid_in, eng_mode, eng_x, eng_y, eng_z,
        output rsp_valid, rsp_id, rsp_cos, rsp_sin, rsp_atan, rsp_err
    );

    modport master (
        output req_valid, req_mode, req_x, req_y, req_z,
        output eng_valid_out, eng_cos, eng_sin, eng_tan_in,
        output rsp_ready,
        input  req_ready,
        input  eng_valid_in, eng_mode, eng_x, eng_y, eng_z,
        input  rsp_valid, rsp_id, rsp_cos, rsp_sin, rsp_atan, rsp_err
    );

endinterface

// File: rtl/cordic_rr_picker.sv
// Round-robin winner select: first set req bit after last_winner, wrapping.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module cordic_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_winner,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     idx
);

    always_comb begin : pick
        int  cand;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        // offsets 1..NUM_REQ visit last_winner itself last
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_winner) + off) % NUM_REQ;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/cordic_req_arbiter.sv
// Shares one iterative CORDIC engine among NUM_REQ requesters, one op in flight;
// CORDIC_ARB_TIMEOUT_EN adds a WAIT watchdog. Latency: grant T, engine start T+1.
// Backpressure: response held until rsp_ready; no grants while busy or holding.
module cordic_req_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    cordic_req_arbiter_if.slave  bus
);

    localparam int IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("cordic_req_arbiter: parameter out of range");
    end

    arb_state_t       state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [WIDTH-1:0] cos_q, cos_d, sin_q, sin_d, atan_q, atan_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDW-1:0]     pick_idx;

    cordic_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_picker (
        .req         (bus.req_valid),
        .last_winner (last_q),
        .gnt         (pick_gnt),
        .idx         (pick_idx)
    );

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        atan_d  = atan_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|pick_gnt) begin
                    id_d    = pick_idx;
                    mode_d  = bus.req_mode[pick_idx];
                    x_d     = bus.req_x[pick_idx];
                    y_d     = bus.req_y[pick_idx];
                    z_d     = bus.req_z[pick_idx];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
`ifdef CORDIC_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
`ifdef CORDIC_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (bus.eng_valid_out) begin
                    cos_d   = bus.eng_cos;
                    sin_d   = bus.eng_sin;
                    atan_d  = bus.eng_tan_in;
`ifdef CORDIC_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = ST_HOLD;
                end
`ifdef CORDIC_ARB_TIMEOUT_EN
                // cnt_q counts completed WAIT cycles; this is cycle TIMEOUT_CYC
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    cos_d   = '0;
                    sin_d   = '0;
                    atan_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_HOLD;
                end
`endif
            end
            ST_HOLD: begin
                if (bus.rsp_ready) begin
                    last_d  = id_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= IDW'(NUM_REQ - 1);
            id_q    <= '0;
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            atan_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            atan_q  <= atan_d;
        end
    end

`ifdef CORDIC_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready    = (state_q == ST_IDLE) ? pick_gnt : '0;
    assign bus.eng_valid_in = (state_q == ST_ISSUE);
    assign bus.eng_mode     = mode_q;
    assign bus.eng_x        = x_q;
    assign bus.eng_y        = y_q;
    assign bus.eng_z        = z_q;
    assign bus.rsp_valid    = (state_q == ST_HOLD);
    assign bus.rsp_id       = id_q;
    assign bus.rsp_cos      = cos_q;
    assign bus.rsp_sin      = sin_q;
    assign bus.rsp_atan     = atan_q;

endmodule
